// File: rtl/fifo_sched.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sched
// Purpose  : Scheduler in front of a shared single-port 8-bit FIFO. Two
//            producers (A, B) and one consumer compete for the FIFO's
//            push/pop port. A round-robin priority FSM grants at most one
//            requester per cycle. A local occupancy count keeps grants from
//            pushing into a full FIFO or popping from an empty one.
//
// Ports    : clk, rst          - rising-edge clock, synchronous active-high
//                                reset
//            req_a/data_a/gnt_a - producer A push handshake (gnt combinational)
//            req_b/data_b/gnt_b - producer B push handshake (gnt combinational)
//            pop_req/pop_gnt    - consumer pop handshake (gnt combinational)
//            fifo_push/fifo_pop/fifo_datain - registered FIFO controls
//            fifo_dataout       - FIFO read data
//            rd_data/rd_valid   - popped word to the consumer
//            count/full/empty   - registered occupancy status
//
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sched #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   // producer A
   input  logic             req_a,
   input  logic [7:0]       data_a,
   output logic             gnt_a,
   // producer B
   input  logic             req_b,
   input  logic [7:0]       data_b,
   output logic             gnt_b,
   // consumer
   input  logic             pop_req,
   output logic             pop_gnt,
   // FIFO side
   output logic             fifo_push,
   output logic             fifo_pop,
   output logic [7:0]       fifo_datain,
   input  logic [7:0]       fifo_dataout,
   // read return
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   // occupancy status
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   // ------------------------------------------------------------------------
   // Constants and state encoding
   // ------------------------------------------------------------------------
   localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_zero  = '0;

   // The state names the requester searched first in the current cycle.
   typedef enum logic [1:0] {
      PRI_A   = 2'd0,
      PRI_B   = 2'd1,
      PRI_POP = 2'd2
   } pri_t;

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   pri_t             r_state;
   pri_t             w_state_nxt;

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic             r_full;
   logic             r_empty;

   logic             w_elig_a;
   logic             w_elig_b;
   logic             w_elig_pop;

   logic             w_gnt_a;
   logic             w_gnt_b;
   logic             w_gnt_pop;

   logic             r_push;
   logic             r_pop;
   logic [7:0]       r_datain;
   logic [7:0]       w_datain_nxt;
   logic             r_rd_valid;

   // ------------------------------------------------------------------------
   // Eligibility
   // Grants are gated by rst so that nothing is accepted while reset is held;
   // a requester that sees its grant during reset would otherwise drop its
   // request for an operation that the reset then throws away.
   // ------------------------------------------------------------------------
   assign w_elig_a   = !rst && req_a   && (r_count < c_depth);
   assign w_elig_b   = !rst && req_b   && (r_count < c_depth);
   assign w_elig_pop = !rst && pop_req && (r_count != c_zero);

   // ------------------------------------------------------------------------
   // Priority FSM: next state and grants
   // Search order wraps A -> B -> POP -> A starting at the current state;
   // after a grant the search restarts just past the winner.
   // ------------------------------------------------------------------------
   always_comb begin
      w_gnt_a     = 1'b0;
      w_gnt_b     = 1'b0;
      w_gnt_pop   = 1'b0;
      w_state_nxt = r_state;

      case (r_state)
         PRI_A: begin
            if (w_elig_a) begin
               w_gnt_a     = 1'b1;
               w_state_nxt = PRI_B;
            end else if (w_elig_b) begin
               w_gnt_b     = 1'b1;
               w_state_nxt = PRI_POP;
            end else if (w_elig_pop) begin
               w_gnt_pop   = 1'b1;
               w_state_nxt = PRI_A;
            end
         end

         PRI_B: begin
            if (w_elig_b) begin
               w_gnt_b     = 1'b1;
               w_state_nxt = PRI_POP;
            end else if (w_elig_pop) begin
               w_gnt_pop   = 1'b1;
               w_state_nxt = PRI_A;
            end else if (w_elig_a) begin
               w_gnt_a     = 1'b1;
               w_state_nxt = PRI_B;
            end
         end

         PRI_POP: begin
            if (w_elig_pop) begin
               w_gnt_pop   = 1'b1;
               w_state_nxt = PRI_A;
            end else if (w_elig_a) begin
               w_gnt_a     = 1'b1;
               w_state_nxt = PRI_B;
            end else if (w_elig_b) begin
               w_gnt_b     = 1'b1;
               w_state_nxt = PRI_POP;
            end
         end

         default: begin
            // Unreachable encoding: recover to the reset priority.
            w_state_nxt = PRI_A;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Occupancy and FIFO command datapath
   // Only one grant can be high, so increment and decrement never overlap.
   // ------------------------------------------------------------------------
   always_comb begin
      w_count_nxt = r_count;
      if (w_gnt_a || w_gnt_b) begin
         w_count_nxt = r_count + c_one;
      end else if (w_gnt_pop) begin
         w_count_nxt = r_count - c_one;
      end
   end

   // Idle cycles drive zero data so the FIFO bus is quiet when not pushing.
   always_comb begin
      w_datain_nxt = 8'h00;
      if (w_gnt_a) begin
         w_datain_nxt = data_a;
      end else if (w_gnt_b) begin
         w_datain_nxt = data_b;
      end
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= PRI_A;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Registered FIFO commands, occupancy and read-valid
   // rd_valid trails fifo_pop by one cycle: the FIFO registers its output on
   // the edge that ends the pop cycle, so the word is on fifo_dataout only in
   // the cycle after that.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_push     <= 1'b0;
         r_pop      <= 1'b0;
         r_datain   <= 8'h00;
         r_rd_valid <= 1'b0;
         r_count    <= c_zero;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
      end else begin
         r_push     <= w_gnt_a || w_gnt_b;
         r_pop      <= w_gnt_pop;
         r_datain   <= w_datain_nxt;
         r_rd_valid <= r_pop;
         r_count    <= w_count_nxt;
         r_full     <= (w_count_nxt == c_depth);
         r_empty    <= (w_count_nxt == c_zero);
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign gnt_a       = w_gnt_a;
   assign gnt_b       = w_gnt_b;
   assign pop_gnt     = w_gnt_pop;

   assign fifo_push   = r_push;
   assign fifo_pop    = r_pop;
   assign fifo_datain = r_datain;

   assign rd_data     = fifo_dataout;
   assign rd_valid    = r_rd_valid;

   assign count       = r_count;
   assign full        = r_full;
   assign empty       = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sched
// Purpose  : Self-checking bench for fifo_sched. Includes a behavioural model
//            of the attached FIFO and a reference model of the scheduler
//            (round-robin pointer, occupancy count, queue of accepted words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_sched;

   localparam int DEPTH = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_a, req_b, pop_req;
   logic [7:0]       data_a, data_b;
   logic             gnt_a, gnt_b, pop_gnt;
   logic             fifo_push, fifo_pop;
   logic [7:0]       fifo_datain;
   logic [7:0]       fifo_dataout;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic [CNT_W-1:0] count;
   logic             full, empty;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fifo_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_a        (req_a),
      .data_a       (data_a),
      .gnt_a        (gnt_a),
      .req_b        (req_b),
      .data_b       (data_b),
      .gnt_b        (gnt_b),
      .pop_req      (pop_req),
      .pop_gnt      (pop_gnt),
      .fifo_push    (fifo_push),
      .fifo_pop     (fifo_pop),
      .fifo_datain  (fifo_datain),
      .fifo_dataout (fifo_dataout),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .count        (count),
      .full         (full),
      .empty        (empty)
   );

   // ------------------------------------------------------------------------
   // Attached FIFO: stores pushed words, registers the head on a pop.
   // ------------------------------------------------------------------------
   logic [7:0] fifo_mem[$];
   always @(posedge clk) begin
      if (rst) begin
         fifo_mem.delete();
         fifo_dataout <= 8'h00;
      end else begin
         if (fifo_push) fifo_mem.push_back(fifo_datain);
         if (fifo_pop && fifo_mem.size() > 0) fifo_dataout <= fifo_mem.pop_front();
      end
   end

   // ------------------------------------------------------------------------
   // Reference model
   // m_ptr: 0=A, 1=B, 2=POP is the requester searched first.
   // ------------------------------------------------------------------------
   int         m_ptr;
   int         m_count;
   bit         m_push, m_pop, m_rdv;
   logic [7:0] m_datain, m_pend, m_rd_exp;
   logic [7:0] m_q[$];

   logic [19:0] obs, exp_v;
   assign obs = {gnt_a, gnt_b, pop_gnt, fifo_push, fifo_pop, fifo_datain,
                 count, full, empty, rd_valid};

   function automatic int winner();
      bit el[3];
      int w;
      w     = -1;
      el[0] = !rst && req_a   && (m_count < DEPTH);
      el[1] = !rst && req_b   && (m_count < DEPTH);
      el[2] = !rst && pop_req && (m_count > 0);
      for (int k = 0; k < 3; k++) begin
         int idx;
         idx = (m_ptr + k) % 3;
         if (w < 0 && el[idx]) w = idx;
      end
      return w;
   endfunction

   function automatic logic [19:0] expect_vec();
      int w;
      w = winner();
      return {w == 0, w == 1, w == 2, m_push, m_pop, m_datain, 4'(m_count),
              m_count == DEPTH, m_count == 0, m_rdv};
   endfunction

   // Advance the model across one rising edge using the current inputs.
   task automatic model_tick();
      int w;
      w = winner();
      if (rst) begin
         m_ptr = 0; m_count = 0; m_push = 0; m_pop = 0; m_rdv = 0;
         m_datain = 8'h00; m_pend = 8'h00; m_rd_exp = 8'h00;
         m_q.delete();
      end else begin
         m_rdv    = m_pop;
         m_rd_exp = m_pend;
         m_push   = (w == 0) || (w == 1);
         m_pop    = (w == 2);
         m_datain = (w == 0) ? data_a : (w == 1) ? data_b : 8'h00;
         if (w == 0) begin m_q.push_back(data_a); m_count++; end
         if (w == 1) begin m_q.push_back(data_b); m_count++; end
         if (w == 2) begin m_pend = m_q.pop_front(); m_count--; end
         if (w >= 0) m_ptr = (w + 1) % 3;
      end
   endtask

   // Unchecked cycle used for setup; the model still follows the DUT.
   task automatic idle_tick();
      @(negedge clk);
      model_tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_a = 0; req_b = 0; pop_req = 0;
      idle_tick();
      idle_tick();
      rst = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1; req_a = 1; req_b = 1; pop_req = 1;
      data_a = 8'($urandom); data_b = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp_v = expect_vec();
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset cycle %0d: outputs %h, expected %h", i, obs, exp_v);
         end
         model_tick();
         @(posedge clk); #1;
      end
      rst = 1'b0;
      // Priority restarts at A: with count 0 A must win over B.
      @(negedge clk);
      n_checks++;
      if ({gnt_a, gnt_b, pop_gnt, count, empty} !== {3'b100, 4'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_release: gnt_a/b/pop,count,empty %b %b %b %0d %b, expected 1 0 0 0 1",
                  gnt_a, gnt_b, pop_gnt, count, empty);
      end
      model_tick();
      @(posedge clk); #1;
      req_a = 0; req_b = 0; pop_req = 0;
   endtask

   task automatic test_single_path();
      int ga = -1, pg = -1, ps = -1, rv = -1;
      logic [7:0] ps_d = 8'hxx, rv_d = 8'hxx;
      logic [CNT_W-1:0] cnt[6];
      do_reset();
      data_a = 8'd1;
      for (int i = 0; i < 6; i++) begin
         req_a   = (i == 0);
         pop_req = (i == 1);
         @(negedge clk);
         exp_v = expect_vec();
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL single cycle %0d: outputs %h, expected %h", i, obs, exp_v);
         end
         if (m_rdv) begin
            n_checks++;
            if (rd_data !== m_rd_exp) begin
               n_fail++;
               $display("FAIL single_rd cycle %0d: rd_data %h, expected %h", i, rd_data, m_rd_exp);
            end
         end
         cnt[i] = count;
         if (gnt_a)     ga = i;
         if (pop_gnt)   pg = i;
         if (fifo_push) begin ps = i; ps_d = fifo_datain; end
         if (rd_valid)  begin rv = i; rv_d = rd_data; end
         model_tick();
         @(posedge clk); #1;
      end
      req_a = 0; pop_req = 0;
      n_checks++;
      if (ga != 0 || ps != 1 || ps_d !== 8'd1) begin
         n_fail++;
         $display("FAIL single_push: gnt_a@%0d push@%0d datain %h, expected 0 1 01", ga, ps, ps_d);
      end
      n_checks++;
      if (pg != 1 || rv != 3 || rv_d !== 8'd1) begin
         n_fail++;
         $display("FAIL single_pop: pop_gnt@%0d rd_valid@%0d rd_data %h, expected 1 3 01", pg, rv, rv_d);
      end
      n_checks++;
      if ({cnt[0], cnt[1], cnt[2]} !== {4'd0, 4'd1, 4'd0}) begin
         n_fail++;
         $display("FAIL single_count: %0d %0d %0d, expected 0 1 0", cnt[0], cnt[1], cnt[2]);
      end
   endtask

   task automatic test_contention();
      int seq[6];
      int wexp[6] = '{0, 1, 2, 0, 1, 2};
      bit both = 0;
      do_reset();
      // A, B, A pushes then one pop: count 2 with A next in line.
      req_a = 1; data_a = 8'($urandom); idle_tick();
      req_a = 0; req_b = 1; data_b = 8'($urandom); idle_tick();
      req_b = 0; req_a = 1; data_a = 8'($urandom); idle_tick();
      req_a = 0; pop_req = 1; idle_tick();
      req_a = 1; req_b = 1; pop_req = 1;
      data_a = 8'($urandom); data_b = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         exp_v = expect_vec();
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL contention cycle %0d: outputs %h, expected %h", i, obs, exp_v);
         end
         if (m_rdv) begin
            n_checks++;
            if (rd_data !== m_rd_exp) begin
               n_fail++;
               $display("FAIL contention_rd cycle %0d: rd_data %h, expected %h", i, rd_data, m_rd_exp);
            end
         end
         seq[i] = gnt_a ? 0 : gnt_b ? 1 : pop_gnt ? 2 : -1;
         if (fifo_push && fifo_pop) both = 1;
         model_tick();
         @(posedge clk); #1;
         if (seq[i] == 0) data_a = 8'($urandom);
         if (seq[i] == 1) data_b = 8'($urandom);
      end
      req_a = 0; req_b = 0; pop_req = 0;
      n_checks++;
      if (seq != wexp) begin
         n_fail++;
         $display("FAIL contention_order: %0d %0d %0d %0d %0d %0d, expected 0 1 2 0 1 2",
                  seq[0], seq[1], seq[2], seq[3], seq[4], seq[5]);
      end
      n_checks++;
      if (both) begin
         n_fail++;
         $display("FAIL contention_pushpop: push and pop both high, expected never");
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int k = 6; k <= 13; k++) begin
         req_a = 1; data_a = 8'(k);
         @(negedge clk);
         exp_v = expect_vec();
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL full_fill word %0d: outputs %h, expected %h", k, obs, exp_v);
         end
         model_tick();
         @(posedge clk); #1;
      end
      req_a = 0; req_b = 1; data_b = 8'd14;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (gnt_b !== 1'b0 || full !== 1'b1 || count !== 4'd8) begin
            n_fail++;
            $display("FAIL full_block cycle %0d: gnt_b %b full %b count %0d, expected 0 1 8",
                     i, gnt_b, full, count);
         end
         model_tick();
         @(posedge clk); #1;
      end
      pop_req = 1;
      @(negedge clk);
      n_checks++;
      if (pop_gnt !== 1'b1 || gnt_b !== 1'b0) begin
         n_fail++;
         $display("FAIL full_pop: pop_gnt %b gnt_b %b, expected 1 0", pop_gnt, gnt_b);
      end
      model_tick();
      @(posedge clk); #1;
      pop_req = 0;
      @(negedge clk);
      n_checks++;
      if (gnt_b !== 1'b1) begin
         n_fail++;
         $display("FAIL full_accept_b: gnt_b %b, expected 1", gnt_b);
      end
      model_tick();
      @(posedge clk); #1;
      req_b = 0;
      @(negedge clk);
      n_checks++;
      if (count !== 4'd8 || full !== 1'b1) begin
         n_fail++;
         $display("FAIL full_refill: count %0d full %b, expected 8 1", count, full);
      end
      model_tick();
      @(posedge clk); #1;
      // Drain and check every word comes back in order.
      pop_req = 1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         exp_v = expect_vec();
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL full_drain cycle %0d: outputs %h, expected %h", i, obs, exp_v);
         end
         if (m_rdv) begin
            n_checks++;
            if (rd_data !== m_rd_exp) begin
               n_fail++;
               $display("FAIL full_drain_rd cycle %0d: rd_data %h, expected %h", i, rd_data, m_rd_exp);
            end
         end
         model_tick();
         @(posedge clk); #1;
      end
      pop_req = 0;
   endtask

   task automatic test_empty();
      int ga = -1, pg = -1, rv = -1;
      bit early = 0;
      bit pop_seen = 0;
      logic [7:0] rv_d = 8'hxx;
      do_reset();
      data_a = 8'd5;
      for (int i = 0; i < 8; i++) begin
         pop_req = !pop_seen;
         req_a   = (i == 3);
         @(negedge clk);
         exp_v = expect_vec();
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL empty cycle %0d: outputs %h, expected %h", i, obs, exp_v);
         end
         if (i < 3 && (pop_gnt || fifo_pop)) early = 1;
         if (gnt_a)    ga = i;
         if (pop_gnt)  begin pg = i; pop_seen = 1; end
         if (rd_valid) begin rv = i; rv_d = rd_data; end
         model_tick();
         @(posedge clk); #1;
      end
      req_a = 0; pop_req = 0;
      n_checks++;
      if (early) begin
         n_fail++;
         $display("FAIL empty_nopop: pop granted or issued on an empty FIFO, expected none");
      end
      n_checks++;
      if (ga != 3 || pg != 4 || rv != 6 || rv_d !== 8'd5) begin
         n_fail++;
         $display("FAIL empty_push_pop: gnt_a@%0d pop_gnt@%0d rd_valid@%0d rd_data %h, expected 3 4 6 05",
                  ga, pg, rv, rv_d);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      req_a = 1; data_a = 8'($urandom);
      @(negedge clk);
      n_checks++;
      if (gnt_a !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_grant: gnt_a %b, expected 1", gnt_a);
      end
      rst = 1'b1;
      model_tick();
      @(posedge clk); #1;
      rst = 1'b0; req_a = 0;
      @(negedge clk);
      exp_v = expect_vec();
      n_checks++;
      if (obs !== exp_v || fifo_push !== 1'b0 || count !== 4'd0) begin
         n_fail++;
         $display("FAIL midreset_state: outputs %h, expected %h", obs, exp_v);
      end
      model_tick();
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      bit ga, gb, gp;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         exp_v = expect_vec();
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL random cycle %0d: outputs %h, expected %h", i, obs, exp_v);
         end
         if (m_rdv) begin
            n_checks++;
            if (rd_data !== m_rd_exp) begin
               n_fail++;
               $display("FAIL random_rd cycle %0d: rd_data %h, expected %h", i, rd_data, m_rd_exp);
            end
         end
         ga = gnt_a; gb = gnt_b; gp = pop_gnt;
         model_tick();
         @(posedge clk); #1;
         // Requests stay up with stable data until granted.
         if (!req_a || ga) begin
            req_a = ($urandom_range(0, 99) < 45); data_a = 8'($urandom);
         end
         if (!req_b || gb) begin
            req_b = ($urandom_range(0, 99) < 45); data_b = 8'($urandom);
         end
         if (!pop_req || gp) pop_req = ($urandom_range(0, 99) < 50);
      end
      req_a = 0; req_b = 0; pop_req = 0;
   endtask

   // ------------------------------------------------------------------------
   // Sequencer and watchdog
   // ------------------------------------------------------------------------
   initial begin
      rst = 1'b1; req_a = 0; req_b = 0; pop_req = 0;
      data_a = 8'h00; data_b = 8'h00;
      m_ptr = 0; m_count = 0; m_push = 0; m_pop = 0; m_rdv = 0;
      m_datain = 8'h00; m_pend = 8'h00; m_rd_exp = 8'h00;
      @(posedge clk); #1;
      test_reset();
      test_single_path();
      test_contention();
      test_full();
      test_empty();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/fifo_sched.md
# fifo_sched

Request scheduler in front of the shared 8-bit `fifo`. It arbitrates two producers (A, B) and one consumer between the FIFO's single `push`/`pop` port. Decisions are round-robin and occupancy-aware. The block issues at most one FIFO operation per cycle, so it never drives the FIFO's invalid push+pop combination. It keeps its own occupancy count, so no request is ever granted into a full or empty FIFO.

## Interface
- `DEPTH`, 8: FIFO capacity in entries; must match the attached `fifo`.
- `CNT_W`, 4: width of `count`; must be at least ceil(log2(DEPTH+1)).

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `req_a`  in  1  producer A push request
- `data_a`  in  8  producer A data, valid while `req_a`
- `gnt_a`  out  1  combinational accept for A
- `req_b`  in  1  producer B push request
- `data_b`  in  8  producer B data, valid while `req_b`
- `gnt_b`  out  1  combinational accept for B
- `pop_req`  in  1  consumer pop request
- `pop_gnt`  out  1  combinational accept for the consumer
- `fifo_push`  out  1  registered, to `fifo.push`
- `fifo_pop`  out  1  registered, to `fifo.pop`
- `fifo_datain`  out  8  registered, to `fifo.datain`
- `fifo_dataout`  in  8  from `fifo.dataout`
- `rd_data`  out  8  combinational pass-through of `fifo_dataout`
- `rd_valid`  out  1  registered; `rd_data` holds a popped word
- `count`  out  CNT_W  registered occupancy, 0..DEPTH
- `full`  out  1  registered, `count == DEPTH`
- `empty`  out  1  registered, `count == 0`

## Operation
- **Handshakes:** valid/ready style.
  - A transfer occurs on the edge where `req_x && gnt_x`.
  - Each requester holds its request, and its data for A/B, until it sees its grant.
  - A requester may keep `req` high to make back-to-back requests.
- **Eligibility:**
  - A and B are eligible when their `req` is high and `count < DEPTH`.
  - The consumer is eligible when `pop_req` is high and `count > 0`.
- **Priority FSM:** states PRI_A, PRI_B, PRI_POP; reset state is PRI_A.
  - Search order starts at the state's requester and wraps: A → B → POP → A.
  - The first eligible requester is granted. Exactly zero or one grant is high per cycle.
  - After a grant, the FSM moves to the requester following the winner (A→PRI_B, B→PRI_POP, POP→PRI_A).
  - With no grant, the state holds.
- **On a push grant:**
  - Next cycle: `fifo_push`=1, `fifo_datain` = the winner's data.
  - `count` increments at the grant edge.
- **On a pop grant:**
  - Next cycle: `fifo_pop`=1.
  - `count` decrements at the grant edge.
- **Idle cycles:** when nothing is granted, `fifo_push`=`fifo_pop`=0 and `fifo_datain`=0.
- **Invariants:**
  - `fifo_push && fifo_pop` is never high.
  - `count` never exceeds DEPTH and never underflows.
- **Ordering:** a pop granted the cycle after a push to an empty FIFO is legal. The push reaches the FIFO one edge before the pop is issued.
- **Reset** applies in any state:
  - `count`=0, `empty`=1, `full`=0.
  - All grants low, `fifo_push`=`fifo_pop`=0, `fifo_datain`=0, `rd_valid`=0, FSM=PRI_A.
  - An already-granted but unissued operation is dropped.
  - `fifo` shares the same reset, so occupancy stays consistent.

## Timing
- Grants are combinational from the requests, `count` and the FSM state. No request-to-grant register stage.
- Push latency:
  - Grant edge N.
  - `fifo_push` high in cycle N+1.
  - Data is written into the FIFO at edge N+1.
- Pop latency:
  - Grant edge N.
  - `fifo_pop` high in cycle N+1.
  - `rd_valid` high in cycle N+2, one cycle after the FIFO registers its output. `rd_data` is valid in that cycle only.
- `count`, `full` and `empty` reflect every grant taken at or before the current edge.
- Throughput: one operation per cycle in total.
- Fairness: with all three requesters continuously eligible, the grant sequence is A, B, POP, A, …

## Test plan
- **Reset:**
  - Stimulus: hold `rst`=1 for 4 cycles with all requests high.
  - Required: no grants; `count`=0, `empty`=1; FSM=PRI_A after release.
- **Single path:**
  - Stimulus: A pushes 8'd1, then the consumer pops.
  - Required: `fifo_push` one cycle after `gnt_a` with `fifo_datain`=1; `rd_valid` with `rd_data`=1 two cycles after `pop_gnt`; `count` goes 0→1→0.
- **Contention:**
  - Stimulus: A, B and POP all requesting, with `count` starting at 2.
  - Required: grants rotate A, B, POP, A, B, POP; `fifo_push`/`fifo_pop` are never both high.
- **Full:**
  - Stimulus: A pushes 6..13, reaching `count`=8; then B requests with 8'd14.
  - Required: `full`=1 and `gnt_b` stays low until a pop is granted; then B is accepted and `count` returns to 8.
- **Empty:**
  - Stimulus: `pop_req` high with `count`=0.
  - Required: `pop_gnt`=0 and no `fifo_pop`.
  - Stimulus: A then pushes 8'd5.
  - Required: `pop_gnt` no earlier than the cycle after `gnt_a`; `rd_data`=5.
- **Mid-operation reset:**
  - Stimulus: assert `rst` on the edge after `gnt_a`.
  - Required: `fifo_push` low in the next cycle; `count`=0; all outputs at reset values.
